// File: rtl/tick_scheduler_if.sv
// Bus bundle for tick_scheduler: CPU-side config write port, event ack
// handshake and the tick/event/status outputs feeding interrupt logic.
interface tick_scheduler_if #(
    parameter int NCH = 4
);
    localparam int TGT_W = $clog2(NCH) + 1;

    logic             cfg_we;
    logic [TGT_W-1:0] cfg_tgt;
    logic [31:0]      cfg_data;
    logic [NCH-1:0]   evt_ack;
    logic             tick_o;
    logic [NCH-1:0]   evt_pend;
    logic [NCH-1:0]   ovr;
    logic [NCH-1:0]   ch_active;
    logic             irq;

    modport master (
        output cfg_we, cfg_tgt, cfg_data, evt_ack,
        input  tick_o, evt_pend, ovr, ch_active, irq
    );

    modport slave (
        input  cfg_we, cfg_tgt, cfg_data, evt_ack,
        output tick_o, evt_pend, ovr, ch_active, irq
    );
endinterface

// File: rtl/tick_scheduler.sv
// Prescaled base tick shared by NCH one-shot/periodic timer channels with a
// pending/ack event handshake. Define TICK_SCHED_OVR_EN for sticky overrun flags.
module tick_scheduler #(
    parameter int NCH              = 4,
    parameter int PRE_W            = 16,
    parameter int CNT_W            = 16,
    parameter int DEFAULT_PRESCALE = 9999
) (
    input  logic               clk,
    input  logic               rst_n,
    tick_scheduler_if.slave    bus
);
    localparam int TGT_W = $clog2(NCH) + 1;

    logic [PRE_W-1:0] prescale;
    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    logic             pre_wr;

    logic [CNT_W-1:0] cnt    [NCH];
    logic [CNT_W-1:0] period [NCH];
    logic [NCH-1:0]   periodic;
    logic [NCH-1:0]   active;
    logic [NCH-1:0]   pend;
    logic [NCH-1:0]   wr_ch;
    logic [NCH-1:0]   expire;
    logic [CNT_W-1:0] wr_period;
    logic             unused_cfg;

    assign pre_wr    = bus.cfg_we && (bus.cfg_tgt == TGT_W'(NCH));
    assign wr_period = bus.cfg_data[CNT_W-1:0];
    // Only some cfg_data bits matter for a given build width.
    assign unused_cfg = ^bus.cfg_data;

    // A prescaler write restarts the count so the new period begins cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            prescale <= PRE_W'(DEFAULT_PRESCALE);
            pre_cnt  <= '0;
            tick     <= 1'b0;
        end else if (pre_wr) begin
            prescale <= bus.cfg_data[PRE_W-1:0];
            pre_cnt  <= '0;
            tick     <= 1'b0;
        end else begin
            tick    <= (pre_cnt == prescale);
            pre_cnt <= (pre_cnt == prescale) ? '0 : pre_cnt + PRE_W'(1);
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a bit unassigned (no latches).
        wr_ch  = '0;
        expire = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_ch[i]  = bus.cfg_we && (bus.cfg_tgt == TGT_W'(i));
            expire[i] = tick && active[i] && !wr_ch[i] && (cnt[i] == CNT_W'(1));
        end
    end

    // A channel write on a tick edge wins: no decrement and no expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: counter/period arrays are reset explicitly; they are flops,
            // not RAM, and software may read status before programming them.
            for (int i = 0; i < NCH; i++) begin
                cnt[i]    <= '0;
                period[i] <= '0;
            end
            periodic <= '0;
            active   <= '0;
            pend     <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wr_ch[i]) begin
                    period[i]   <= wr_period;
                    cnt[i]      <= wr_period;
                    periodic[i] <= bus.cfg_data[30];
                    active[i]   <= bus.cfg_data[31] && (wr_period != '0);
                end else if (tick && active[i]) begin
                    if (cnt[i] == CNT_W'(1)) begin
                        if (periodic[i]) begin
                            cnt[i] <= period[i];
                        end else begin
                            cnt[i]    <= '0;
                            active[i] <= 1'b0;
                        end
                    end else begin
                        cnt[i] <= cnt[i] - CNT_W'(1);
                    end
                end

                if (expire[i]) begin
                    pend[i] <= 1'b1;
                end else if (bus.evt_ack[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

`ifdef TICK_SCHED_OVR_EN
    logic [NCH-1:0] ovr_q;

    // Overrun: a new expiry lands on an unacknowledged pending event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wr_ch[i]) begin
                    ovr_q[i] <= 1'b0;
                end else if (expire[i] && pend[i] && !bus.evt_ack[i]) begin
                    ovr_q[i] <= 1'b1;
                end
            end
        end
    end

    assign bus.ovr = ovr_q;
`else
    assign bus.ovr = '0;
`endif

    assign bus.tick_o    = tick;
    assign bus.evt_pend  = pend;
    assign bus.ch_active = active;
    assign bus.irq       = |pend;

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Programmable periodic-event scheduler for the peripheral bus. It owns a configurable prescaler that produces the base device tick. It multiplexes that tick across NCH independent software timer channels, each one-shot or periodic. Each expiry raises a per-channel event that a consumer acknowledges through a pending/ack handshake. It sits beside the bus interconnect, configured by the CPU-side register write port and feeding interrupt and status logic.

## Interface

- NCH, 4, number of timer channels (1..8)
- PRE_W, 16, prescaler width (≤32)
- CNT_W, 16, channel period/counter width (≤30)
- DEFAULT_PRESCALE, 9999, prescale value loaded at reset (tick period = value+1 clk cycles)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_we  in  1  config write strobe, one-cycle
- cfg_tgt  in  $clog2(NCH)+1  target: 0..NCH-1 = channel, NCH = prescaler, others ignored
- cfg_data  in  32  channel: [CNT_W-1:0] period P, [30] periodic, [31] enable; prescaler: [PRE_W-1:0]
- evt_ack  in  NCH  per-channel event acknowledge
- tick_o  out  1  base tick pulse, one cycle
- evt_pend  out  NCH  per-channel event pending
- ovr  out  NCH  per-channel sticky overrun
- ch_active  out  NCH  channel enabled and counting
- irq  out  1  OR of evt_pend

## Operation

- Prescaler: pre_cnt counts 0..prescale, wraps to 0; tick_o registered = (pre_cnt == prescale). prescale=0 → tick_o high every cycle.
- Prescaler write: prescale ← cfg_data[PRE_W-1:0], pre_cnt ← 0, tick_o ← 0 on that edge.
- Channel write: period ← P, cnt ← P, mode ← bit30, ch_active ← bit31 & (P≠0); ovr[ch] ← 0; evt_pend unchanged. P=0 disables the channel.
- Per channel on edge with tick_o=1 and ch_active=1, no write to that channel:
  - cnt==1: expire; periodic → cnt ← period; one-shot → cnt ← 0, ch_active ← 0.
  - else cnt ← cnt−1 (never wraps; cnt≥2).
- Channel write and tick same edge: write wins; no decrement, no expiry.
- Expiry: evt_pend ← 1. If evt_pend already 1 and evt_ack=0 same edge → ovr ← 1.
- evt_ack=1, no expiry: evt_pend ← 0. Ack coincident with expiry: evt_pend stays 1, ovr not set. Ack with pend=0: no effect.
- Channels fully independent; no arbitration needed between simultaneous expiries.
- Reset values: tick_o 0, evt_pend 0, ovr 0, ch_active 0, irq 0, pre_cnt 0, all cnt/period 0, prescale DEFAULT_PRESCALE.

## Timing

- All outputs registered; irq is combinational OR of registered evt_pend (no further latency).
- First tick_o: clk edge number DEFAULT_PRESCALE+1 after rst_n release (pre_cnt=k after edge k). Thereafter every prescale+1 cycles.
- Expiry visible on evt_pend the cycle after the tick_o cycle; ch_active drops in the same cycle for one-shot.
- Channel with period P enabled before tick n expires on tick n+P−1 (the P-th tick after the write).
- Config write takes effect on the next edge; no busy state, cfg_we accepted every cycle.
- rst_n assertion mid-operation clears all state immediately, independent of clk.

## Configuration

- TICK_SCHED_OVR_EN defined: overrun detection and sticky ovr flags as above.
- Undefined: overrun logic not compiled; ovr port present, tied to 0; evt_pend behaviour unchanged.

## Test plan

- Reset release, DEFAULT_PRESCALE=4 → tick_o high at edges 5, 10, 15, …; all other outputs 0.
- Ch0 write {en=1, periodic=1, P=3}; ack each event within 2 cycles → evt_pend[0] rises after ticks 3, 6, 9; irq tracks; ovr[0]=0.
- Ch1 write {en=1, periodic=0, P=2} → single evt_pend[1] after tick 2; ch_active[1] falls same cycle; no further events over 10 ticks.
- Ch2 {en=1, periodic=1, P=1}, no ack → ovr[2]=1 after second tick; rewrite ch2 → ovr[2]=0; ack in the same cycle as an expiry → evt_pend[2] stays 1, ovr[2] stays 0.
- Prescaler write 0 mid-count → tick_o 0 on next cycle, then high every cycle; write 2 → tick period 3.
- Assert rst_n mid-count with events pending → all outputs 0 immediately; after release, prescale is back to DEFAULT_PRESCALE and channels are inactive.
